// File: rtl/sevenseg_scan_mux.sv
// Multiplexed driver for an N-digit common-anode seven-segment display.
// Digits are scanned right to left with one slot per digit. All display
// inputs are snapshotted once per frame so a frame never shows a mix of old
// and new data. Anode and cathode drives are active-low and registered.
`timescale 1ns/1ps

module sevenseg_scan_mux #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLOCK_FREQ  = 100000000,
    parameter int DIGIT_US    = 1000,
    parameter int BRIGHT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] display,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    input  logic                    hex_mode,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [7:0]              cathode_n,
    output logic                    frame_start
);

    // Slot length in clock cycles and the widths needed to count it.
    localparam int TICKS  = CLOCK_FREQ / 1000000 * DIGIT_US;
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TICK_W-1:0]      TICK_LOAD   = TICK_W'(TICKS - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_BITS-1:0] BRIGHT_FULL = '1;

    // Segment pattern {g,f,e,d,c,b,a}, active-high. Nibbles above 9 are
    // blank unless hex display is selected.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        if (!hex && (nib > 4'h9)) begin
            seg = 7'h00;
        end
        return seg;
    endfunction

    // Leading-zero mask: walking down from the leftmost digit, zero nibbles
    // are blanked until a nonzero nibble or a lit decimal point is reached.
    // Digit 0 always shows so a value of zero still displays "0".
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [4*NUM_DIGITS-1:0] disp,
        input logic [NUM_DIGITS-1:0]   dps
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  searching;
        mask      = '0;
        searching = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (searching && (disp[4*i +: 4] == 4'h0) && !dps[i]) begin
                mask[i] = 1'b1;
            end else begin
                searching = 1'b0;
            end
        end
        return mask;
    endfunction

    // Scan control state
    logic [TICK_W-1:0]      r_tick;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_first;
    logic [BRIGHT_BITS-1:0] r_pwm;

    // Per-frame snapshot of the display inputs
    logic [4*NUM_DIGITS-1:0] r_snap_disp;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic [NUM_DIGITS-1:0]   r_snap_en;
    logic                    r_snap_hex;
    logic                    r_snap_lz;
    logic [BRIGHT_BITS-1:0]  r_snap_bright;

    // Registered pin drives
    logic [NUM_DIGITS-1:0] r_anode_n;
    logic [7:0]            r_cathode_n;

    // Next-state values
    logic                    w_reload;
    logic                    w_wrap;
    logic [TICK_W-1:0]       w_tick_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [BRIGHT_BITS-1:0]  w_pwm_nxt;
    logic [4*NUM_DIGITS-1:0] w_snap_disp;
    logic [NUM_DIGITS-1:0]   w_snap_dp;
    logic [NUM_DIGITS-1:0]   w_snap_en;
    logic                    w_snap_hex;
    logic                    w_snap_lz;
    logic [BRIGHT_BITS-1:0]  w_snap_bright;

    // Digit currently being presented and its decoded drive
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic [NUM_DIGITS-1:0] w_sel;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_en;
    logic                  w_supp;
    logic                  w_pwm_on;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_anode_nxt;
    logic [7:0]            w_cathode_nxt;

    // A slot ends when the tick counter reads zero; a frame ends after the
    // last digit's slot, or at the very first slot after reset.
    assign w_reload   = !reset && (r_tick == '0);
    assign w_wrap     = w_reload && (r_first || (r_idx == IDX_LAST));
    assign w_tick_nxt = w_reload ? TICK_LOAD : (r_tick - TICK_W'(1));
    assign w_pwm_nxt  = r_pwm + BRIGHT_BITS'(1);

    // Snapshot is only open on the frame boundary cycle.
    assign w_snap_disp   = w_wrap ? display      : r_snap_disp;
    assign w_snap_dp     = w_wrap ? dp           : r_snap_dp;
    assign w_snap_en     = w_wrap ? digit_enable : r_snap_en;
    assign w_snap_hex    = w_wrap ? hex_mode     : r_snap_hex;
    assign w_snap_lz     = w_wrap ? lz_suppress  : r_snap_lz;
    assign w_snap_bright = w_wrap ? brightness   : r_snap_bright;

    assign w_lz_mask = w_snap_lz ? lz_mask(w_snap_disp, w_snap_dp) : '0;

    // Advance the digit index: restart on a frame boundary, step on a slot boundary.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_wrap) begin
            w_idx_nxt = '0;
        end else if (w_reload) begin
            w_idx_nxt = r_idx + IDX_W'(1);
        end
    end

    // Pick the nibble, decimal point, enable and suppression bit of the next digit.
    always_comb begin
        w_sel  = '0;
        w_nib  = 4'h0;
        w_dp   = 1'b0;
        w_en   = 1'b0;
        w_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_nib    = w_snap_disp[4*i +: 4];
                w_dp     = w_snap_dp[i];
                w_en     = w_snap_en[i];
                w_supp   = w_lz_mask[i];
            end
        end
    end

    // Build the pin drives; outputs are computed from next-state values so the
    // registered pins line up with the index register cycle for cycle.
    always_comb begin
        w_pwm_on      = (w_snap_bright == BRIGHT_FULL) || (w_pwm_nxt < w_snap_bright);
        w_seg         = w_supp ? 7'h00 : seg_decode(w_nib, w_snap_hex);
        w_cathode_nxt = 8'hFF;
        w_anode_nxt   = '1;
        if (w_en) begin
            w_cathode_nxt = ~{w_dp, w_seg};
            if (w_pwm_on) begin
                w_anode_nxt = ~w_sel;
            end
        end
    end

    // Slot timer, digit index, first-frame flag and free-running PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick  <= '0;
            r_idx   <= '0;
            r_first <= 1'b1;
            r_pwm   <= '0;
        end else begin
            r_tick <= w_tick_nxt;
            r_idx  <= w_idx_nxt;
            r_pwm  <= w_pwm_nxt;
            if (w_reload) begin
                r_first <= 1'b0;
            end
        end
    end

    // Frame snapshot of all display inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_disp   <= '0;
            r_snap_dp     <= '0;
            r_snap_en     <= '0;
            r_snap_hex    <= 1'b0;
            r_snap_lz     <= 1'b0;
            r_snap_bright <= '0;
        end else begin
            r_snap_disp   <= w_snap_disp;
            r_snap_dp     <= w_snap_dp;
            r_snap_en     <= w_snap_en;
            r_snap_hex    <= w_snap_hex;
            r_snap_lz     <= w_snap_lz;
            r_snap_bright <= w_snap_bright;
        end
    end

    // Registered anode/cathode pins, all dark during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anode_n   <= '1;
            r_cathode_n <= 8'hFF;
        end else begin
            r_anode_n   <= w_anode_nxt;
            r_cathode_n <= w_cathode_nxt;
        end
    end

    assign anode_n     = r_anode_n;
    assign cathode_n   = r_cathode_n;
    assign frame_start = w_wrap;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Bench for sevenseg_scan_mux: one instance with 4-cycle slots checked cycle
// by cycle, one with 32-cycle slots checked for PWM duty per window.
`timescale 1ns/1ps

module tb_sevenseg_scan_mux;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: TICKS = 4
    logic        rst_a;
    logic [31:0] disp_a;
    logic [7:0]  dp_a, en_a;
    logic        hex_a, lz_a;
    logic [3:0]  br_a;
    logic [7:0]  an_a, ca_a;
    logic        fs_a;

    // Instance B: TICKS = 32
    logic        rst_b;
    logic [31:0] disp_b;
    logic [7:0]  dp_b, en_b;
    logic        hex_b, lz_b;
    logic [3:0]  br_b;
    logic [7:0]  an_b, ca_b;
    logic        fs_b;

    sevenseg_scan_mux #(.NUM_DIGITS(N), .CLOCK_FREQ(1000000), .DIGIT_US(4), .BRIGHT_BITS(4)) dut_a (
        .clk(clk), .reset(rst_a), .display(disp_a), .dp(dp_a), .digit_enable(en_a),
        .hex_mode(hex_a), .lz_suppress(lz_a), .brightness(br_a),
        .anode_n(an_a), .cathode_n(ca_a), .frame_start(fs_a)
    );

    sevenseg_scan_mux #(.NUM_DIGITS(N), .CLOCK_FREQ(1000000), .DIGIT_US(32), .BRIGHT_BITS(4)) dut_b (
        .clk(clk), .reset(rst_b), .display(disp_b), .dp(dp_b), .digit_enable(en_b),
        .hex_mode(hex_b), .lz_suppress(lz_b), .brightness(br_b),
        .anode_n(an_b), .cathode_n(ca_b), .frame_start(fs_b)
    );

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] ca;
        logic       fs;
        string      tag;
    } cyc_exp_t;

    typedef struct {
        int         start;
        int         len;
        logic [7:0] an;
        int         low;
        string      tag;
    } win_exp_t;

    cyc_exp_t qa[$];
    win_exp_t qb[$];
    int n_checks = 0;
    int n_errors = 0;
    logic done_a = 1'b0;
    logic done_b = 1'b0;

    // Expected cathode bytes per frame, byte k = digit k
    localparam logic [63:0] E_7654    = 64'hF882_9299_B0A4_F9C0;
    localparam logic [63:0] E_8888    = 64'h8080_8080_8080_8080;
    localparam logic [63:0] E_A_DEC   = 64'hF882_9299_B0A4_F97F;
    localparam logic [63:0] E_A_HEX   = 64'hF882_9299_B0A4_F908;
    localparam logic [63:0] E_D0_OFF  = 64'hF882_9299_B0A4_F9FF;
    localparam logic [63:0] E_LZ      = 64'hFFFF_FFFF_FFF9_A4C0;
    localparam logic [63:0] E_LZ_DP   = 64'hFFFF_FF40_C0F9_A4C0;

    task automatic push_cyc(input int c, input logic [7:0] an, input logic [7:0] ca,
                            input logic fs, input string tag);
        cyc_exp_t e;
        e.cyc = c; e.an = an; e.ca = ca; e.fs = fs; e.tag = tag;
        qa.push_back(e);
    endtask

    // Frame whose frame_start pulse is at cycle f: digit k shows on cycles
    // f+1+4k .. f+4+4k, and the next frame_start lands on f+32.
    task automatic push_frame(input int f, input logic [63:0] cas, input logic [7:0] en,
                              input string tag);
        logic [7:0] an;
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 4; t++) begin
                an = 8'hFF;
                if (en[k]) an[k] = 1'b0;
                push_cyc(f + 1 + 4*k + t, an, cas[8*k +: 8], (k == N-1) && (t == 3), tag);
            end
        end
    endtask

    task automatic push_win(input int s, input int len, input logic [7:0] an,
                            input int low, input string tag);
        win_exp_t w;
        w.start = s; w.len = len; w.an = an; w.low = low; w.tag = tag;
        qb.push_back(w);
    endtask

    task automatic wait_fs(input bit which, output int fc);
        fc = -1;
        @(posedge clk);
        for (int i = 0; i < 400 && fc < 0; i++) begin
            @(negedge clk);
            if ((which ? fs_b : fs_a) === 1'b1) fc = cyc;
        end
        if (fc < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_start_timeout dut=%0d got no pulse, required one within 400 cycles", which);
        end
    endtask

    // Monitor A: compare every scheduled cycle
    cyc_exp_t ea;
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            if (qa[0].cyc < cyc) begin
                ea = qa.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL %s cycle %0d never sampled (now %0d)", ea.tag, ea.cyc, cyc);
            end else if (qa[0].cyc == cyc) begin
                ea = qa.pop_front();
                n_checks++;
                if (an_a !== ea.an || ca_a !== ea.ca || fs_a !== ea.fs) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d got an=%h ca=%h fs=%b required an=%h ca=%h fs=%b",
                             ea.tag, cyc, an_a, ca_a, fs_a, ea.an, ea.ca, ea.fs);
                end
            end
        end
    end

    // Monitor B: count anode-on cycles across each window
    int b_low = 0;
    int b_bad = 0;
    win_exp_t eb;
    always @(negedge clk) begin
        if (qb.size() > 0) begin
            if (cyc >= qb[0].start + qb[0].len) begin
                eb = qb.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL %s window at %0d never sampled", eb.tag, eb.start);
                b_low = 0;
                b_bad = 0;
            end else if (cyc >= qb[0].start) begin
                if (an_b === qb[0].an) b_low++;
                else if (an_b !== 8'hFF) b_bad++;
                if (cyc == qb[0].start + qb[0].len - 1) begin
                    eb = qb.pop_front();
                    n_checks++;
                    if (b_low != eb.low || b_bad != 0) begin
                        n_errors++;
                        $display("FAIL %s start=%0d got on=%0d stray=%0d required on=%0d stray=0",
                                 eb.tag, eb.start, b_low, b_bad, eb.low);
                    end
                    b_low = 0;
                    b_bad = 0;
                end
            end
        end
    end

    // Stimulus for instance A
    initial begin
        int p;
        int f;
        rst_a = 1'b1; disp_a = 32'h7654_3210; dp_a = 8'h00; en_a = 8'hFF;
        hex_a = 1'b0; lz_a = 1'b0; br_a = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        p = cyc;
        rst_a = 1'b1;
        for (int i = 1; i <= 4; i++) push_cyc(p + i, 8'hFF, 8'hFF, 1'b0, "reset_hold");
        push_cyc(p + 5, 8'hFF, 8'hFF, 1'b1, "reset_release");
        push_frame(p + 5, E_7654, 8'hFF, "scan_7654");
        repeat (5) @(posedge clk);
        #1 rst_a = 1'b0;

        wait_fs(1'b0, f);
        push_frame(f, E_7654, 8'hFF, "frame_keeps_old");
        @(posedge clk); #1;
        @(posedge clk); #1;
        disp_a = 32'h8888_8888;

        wait_fs(1'b0, f);
        push_frame(f, E_8888, 8'hFF, "frame_8888");
        @(posedge clk); #1;
        disp_a = 32'h7654_321A; dp_a = 8'h01;

        wait_fs(1'b0, f);
        push_frame(f, E_A_DEC, 8'hFF, "nib_A_dec");
        @(posedge clk); #1;
        hex_a = 1'b1;

        wait_fs(1'b0, f);
        push_frame(f, E_A_HEX, 8'hFF, "nib_A_hex");
        @(posedge clk); #1;
        en_a = 8'hFE;

        wait_fs(1'b0, f);
        push_frame(f, E_D0_OFF, 8'hFE, "digit0_off");
        @(posedge clk); #1;
        en_a = 8'hFF; disp_a = 32'h0000_0120; dp_a = 8'h00; hex_a = 1'b0; lz_a = 1'b1;

        wait_fs(1'b0, f);
        push_frame(f, E_LZ, 8'hFF, "lz_suppress");
        @(posedge clk); #1;
        dp_a = 8'h10;

        wait_fs(1'b0, f);
        push_frame(f, E_LZ_DP, 8'hFF, "lz_dp_stop");
        done_a = 1'b1;
    end

    // Stimulus for instance B
    initial begin
        int r;
        rst_b = 1'b1; disp_b = 32'h0; dp_b = 8'h00; en_b = 8'hFF;
        hex_b = 1'b0; lz_b = 1'b0; br_b = 4'h4;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        r = cyc;
        push_win(r + 1,  32, 8'hFE, 8, "pwm4_slot0");
        push_win(r + 33, 32, 8'hFD, 8, "pwm4_slot1");
        push_win(r + 65, 16, 8'hFB, 4, "pwm4_half_slot2");
        @(posedge clk); #1;
        br_b = 4'h0;

        wait_fs(1'b1, r);
        push_win(r + 1,  32, 8'hFE, 0, "pwm0_slot0");
        push_win(r + 97, 32, 8'hF7, 0, "pwm0_slot3");
        @(posedge clk); #1;
        br_b = 4'hF;

        wait_fs(1'b1, r);
        push_win(r + 1,   32, 8'hFE, 32, "pwmF_slot0");
        push_win(r + 225, 32, 8'h7F, 32, "pwmF_slot7");
        done_b = 1'b1;
    end

    // Drain the scoreboards and report
    initial begin
        int k;
        wait (done_a && done_b);
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain got %0d/%0d entries left, required 0/0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no completion, required finish before 400us");
        $fatal(1, "watchdog expired");
    end

endmodule
